// File: rtl/elc3_soc_console_writer_pkg.sv
// elc3_console_pkg: shared constants and types for the LC-3 console writer.
//   - screen geometry (COLS x ROWS) and derived cell counts
//   - control codes interpreted by the terminal (CR, LF, BS, FF)
//   - FSM state and cursor-operation enums
package elc3_console_pkg;

  localparam int         COLS         = 80;
  localparam int         ROWS         = 30;
  localparam logic [7:0] BLANK        = 8'h20;
  localparam int         SCREEN_CELLS = COLS * ROWS;          // 2400
  localparam int         SCROLL_CELLS = SCREEN_CELLS - COLS;  // 2320

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam int COL_W  = 7;
  localparam int ROW_W  = 5;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_SCROLL_RD,
    ST_SCROLL_WR,
    ST_CLEAR_ROW,
    ST_CLEAR_ALL
  } state_e;

  typedef enum logic [2:0] {
    CUR_NONE,
    CUR_INC,
    CUR_NL,
    CUR_CR,
    CUR_BS,
    CUR_HOME
  } cur_op_e;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/elc3_soc_console_writer_if.sv
// Bus bundles for the console writer.
//   elc3_console_stream_if : byte stream in (in_data/in_valid/in_ready).
//     master = producer (display-data path), slave = console writer.
//   elc3_console_buf_if    : single-port character buffer access.
//     master = console writer, slave = character buffer RAM.
interface elc3_console_stream_if;
  import elc3_console_pkg::*;

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

interface elc3_console_buf_if;
  import elc3_console_pkg::*;

  logic [ADDR_W-1:0] buf_address;
  logic              buf_chipselect;
  logic              buf_write;
  logic [DATA_W-1:0] buf_writedata;
  logic [DATA_W-1:0] buf_readdata;
  logic              buf_clken;

  modport master (
    output buf_address, output buf_chipselect, output buf_write,
    output buf_writedata, output buf_clken, input buf_readdata
  );
  modport slave (
    input buf_address, input buf_chipselect, input buf_write,
    input buf_writedata, input buf_clken, output buf_readdata
  );
endinterface

// File: rtl/elc3_soc_console_writer_cursor.sv
// elc3_console_cursor: terminal cursor state.
//   Holds column, row and the linear cell address lin = row*COLS + col,
//   which is maintained incrementally so no multiplier is needed.
// Ports:
//   clk, reset_n   clock and asynchronous active-low reset (cursor -> 0,0)
//   op_i           operation applied at the next clock edge
//   col_o, row_o   current column / row
//   lin_o          current linear cell address
//   ovf_o          op_i would advance past the last row (caller must scroll);
//                  the row is held at the last row in that case
module elc3_console_cursor #(
  parameter int COLS = elc3_console_pkg::COLS,
  parameter int ROWS = elc3_console_pkg::ROWS
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  elc3_console_pkg::cur_op_e op_i,
  output logic [6:0]               col_o,
  output logic [4:0]               row_o,
  output logic [11:0]              lin_o,
  output logic                     ovf_o
);
  import elc3_console_pkg::*;

  localparam logic [6:0]  LAST_COL   = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW   = 5'(ROWS - 1);
  localparam logic [11:0] ROW_STRIDE = 12'(COLS);

  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [11:0] lin_q, lin_d;
  logic [11:0] col_ext;

  assign col_ext = {5'd0, col_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q <= '0;
      row_q <= '0;
      lin_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      lin_q <= lin_d;
    end
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    lin_d = lin_q;
    ovf_o = 1'b0;
    unique case (op_i)
      CUR_INC: begin
        if (col_q == LAST_COL) begin
          col_d = '0;
          if (row_q == LAST_ROW) begin
            ovf_o = 1'b1;
            lin_d = lin_q - col_ext;       // start of the same (last) row
          end else begin
            row_d = row_q + 5'd1;
            lin_d = lin_q + 12'd1;         // end of row + 1 is next row start
          end
        end else begin
          col_d = col_q + 7'd1;
          lin_d = lin_q + 12'd1;
        end
      end
      CUR_NL: begin
        col_d = '0;
        if (row_q == LAST_ROW) begin
          ovf_o = 1'b1;
          lin_d = lin_q - col_ext;
        end else begin
          row_d = row_q + 5'd1;
          lin_d = lin_q - col_ext + ROW_STRIDE;
        end
      end
      CUR_CR: begin
        col_d = '0;
        lin_d = lin_q - col_ext;
      end
      CUR_BS: begin
        // No reverse wrap: column 0 stays put.
        if (col_q != '0) begin
          col_d = col_q - 7'd1;
          lin_d = lin_q - 12'd1;
        end
      end
      CUR_HOME: begin
        col_d = '0;
        row_d = '0;
        lin_d = '0;
      end
      default: ;
    endcase
  end

  assign col_o = col_q;
  assign row_o = row_q;
  assign lin_o = lin_q;

endmodule

// File: rtl/elc3_soc_console_writer.sv
// elc3_soc_console_writer: terminal front end for the 80x30 character buffer.
//   Takes console bytes, writes printable characters at the cursor, handles
//   CR/LF/BS/FF, and scrolls by copying rows through the buffer's one port.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   in_if  (stream slave)   in_data / in_valid / in_ready byte stream
//   buf_if (buffer master)  address/chipselect/write/writedata/clken out,
//                           readdata in (valid one cycle after address)
//   cursor_col, cursor_row  current cursor position
//   busy                    high whenever the FSM is not IDLE
module elc3_soc_console_writer #(
  parameter int         COLS           = elc3_console_pkg::COLS,
  parameter int         ROWS           = elc3_console_pkg::ROWS,
  parameter logic [7:0] BLANK          = elc3_console_pkg::BLANK,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  elc3_console_stream_if.slave       in_if,
  elc3_console_buf_if.master         buf_if,
  output logic [6:0]                 cursor_col,
  output logic [4:0]                 cursor_row,
  output logic                       busy
);
  import elc3_console_pkg::*;

  localparam int          SCREEN      = COLS * ROWS;
  localparam int          SCROLL      = SCREEN - COLS;
  localparam logic [11:0] LAST_SCREEN = 12'(SCREEN - 1);
  localparam logic [11:0] LAST_SCROLL = 12'(SCROLL - 1);
  localparam logic [11:0] LAST_ROWCEL = 12'(COLS - 1);
  localparam logic [11:0] SCROLL_BASE = 12'(SCROLL);
  localparam logic [11:0] ROW_STRIDE  = 12'(COLS);
  localparam state_e      RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR_ALL : ST_IDLE;

  state_e      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;     // scroll / clear cell counter
  logic [7:0]  char_q, char_d;   // byte for the WRITE cycle
  logic        adv_q, adv_d;     // WRITE advances the cursor (printable, not BS)

  cur_op_e     cur_op;
  logic        cur_ovf;
  logic [11:0] cur_lin;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;

  logic        in_fire;
  logic [7:0]  in_byte;

  logic        cs, wr;
  logic [11:0] addr;
  logic [7:0]  wdata;

  elc3_console_cursor #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_cursor (
    .clk     (clk),
    .reset_n (reset_n),
    .op_i    (cur_op),
    .col_o   (cur_col),
    .row_o   (cur_row),
    .lin_o   (cur_lin),
    .ovf_o   (cur_ovf)
  );

  assign in_byte = in_if.in_data;
  assign in_fire = (state_q == ST_IDLE) && in_if.in_valid;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
      char_q  <= '0;
      adv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      char_q  <= char_d;
      adv_q   <= adv_d;
    end
  end

  // Cursor operation for this cycle. Kept apart from the next-state logic
  // because the next state depends on the cursor's overflow answer.
  always_comb begin
    cur_op = CUR_NONE;
    unique case (state_q)
      ST_IDLE: begin
        if (in_fire) begin
          if (in_byte == CH_CR)                        cur_op = CUR_CR;
          else if (in_byte == CH_LF)                   cur_op = CUR_NL;
          else if (in_byte == CH_BS && cur_col != '0)  cur_op = CUR_BS;
        end
      end
      ST_WRITE:     if (adv_q)                  cur_op = CUR_INC;
      ST_CLEAR_ALL: if (cnt_q == LAST_SCREEN)   cur_op = CUR_HOME;
      default: ;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    char_d  = char_q;
    adv_d   = adv_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_fire) begin
          if (is_printable(in_byte)) begin
            state_d = ST_WRITE;
            char_d  = in_byte;
            adv_d   = 1'b1;
          end else if (in_byte == CH_LF) begin
            if (cur_ovf) begin
              state_d = ST_SCROLL_RD;
              cnt_d   = '0;
            end
          end else if (in_byte == CH_BS) begin
            // Cursor steps back this edge, so WRITE blanks the new cell.
            if (cur_col != '0) begin
              state_d = ST_WRITE;
              char_d  = BLANK;
              adv_d   = 1'b0;
            end
          end else if (in_byte == CH_FF) begin
            state_d = ST_CLEAR_ALL;
            cnt_d   = '0;
          end
        end
      end
      ST_WRITE: begin
        state_d = cur_ovf ? ST_SCROLL_RD : ST_IDLE;
        cnt_d   = '0;
      end
      ST_SCROLL_RD: state_d = ST_SCROLL_WR;
      ST_SCROLL_WR: begin
        if (cnt_q == LAST_SCROLL) begin
          state_d = ST_CLEAR_ROW;
          cnt_d   = '0;
        end else begin
          state_d = ST_SCROLL_RD;
          cnt_d   = cnt_q + 12'd1;
        end
      end
      ST_CLEAR_ROW: begin
        if (cnt_q == LAST_ROWCEL) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      ST_CLEAR_ALL: begin
        if (cnt_q == LAST_SCREEN) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic. While reset_n is low the bus is forced quiet even though
  // the state register already sits in its post-reset state.
  always_comb begin
    cs    = 1'b0;
    wr    = 1'b0;
    addr  = '0;
    wdata = '0;
    unique case (state_q)
      ST_WRITE: begin
        cs    = 1'b1;
        wr    = 1'b1;
        addr  = cur_lin;
        wdata = char_q;
      end
      ST_SCROLL_RD: begin
        cs   = 1'b1;
        addr = cnt_q + ROW_STRIDE;
      end
      ST_SCROLL_WR: begin
        cs    = 1'b1;
        wr    = 1'b1;
        addr  = cnt_q;
        wdata = buf_if.buf_readdata;
      end
      ST_CLEAR_ROW: begin
        cs    = 1'b1;
        wr    = 1'b1;
        addr  = SCROLL_BASE + cnt_q;
        wdata = BLANK;
      end
      ST_CLEAR_ALL: begin
        cs    = 1'b1;
        wr    = 1'b1;
        addr  = cnt_q;
        wdata = BLANK;
      end
      default: ;
    endcase
    if (!reset_n) begin
      cs    = 1'b0;
      wr    = 1'b0;
      addr  = '0;
      wdata = '0;
    end
  end

  assign buf_if.buf_chipselect = cs;
  assign buf_if.buf_write      = wr;
  assign buf_if.buf_address    = addr;
  assign buf_if.buf_writedata  = wdata;
  assign buf_if.buf_clken      = 1'b1;

  assign in_if.in_ready = (state_q == ST_IDLE) && reset_n;
  assign busy           = (state_q != ST_IDLE);
  assign cursor_col     = cur_col;
  assign cursor_row     = cur_row;

endmodule

// File: doc/elc3_soc_console_writer.md
Name: elc3_soc_console_writer

Overview:
Upstream feeder for the 80x30 text character buffer (2400 bytes, 12-bit address, single port, one-cycle read latency). Accepts a byte stream of console output from the LC-3 display-data path and interprets it as a terminal. Writes printable characters at the cursor and handles CR/LF/BS/FF. Scrolls the screen by copying rows through the buffer's single port.

Parameters:
COLS, 80, characters per row
ROWS, 30, rows per screen
BLANK, 8'h20, fill code for cleared cells
CLEAR_ON_RESET, 1, clear all 2400 cells after reset deassertion before accepting input

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
in_data  in  8  character code
in_valid  in  1  in_data valid
in_ready  out  1  block can accept; transfer when in_valid & in_ready
buf_address  out  12  char buffer address
buf_chipselect  out  1  char buffer select
buf_write  out  1  write strobe (write = chipselect & write)
buf_writedata  out  8  data to char buffer
buf_readdata  in  8  char buffer read data, valid one cycle after address
buf_clken  out  1  tied high
cursor_col  out  7  current column 0..79
cursor_row  out  5  current row 0..29
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, reset_n=0): cursor 0,0. buf_chipselect=0, buf_write=0, buf_address=0, buf_writedata=0, in_ready=0. Next state is CLEAR_ALL if CLEAR_ON_RESET, else IDLE.
- Cursor is kept as col/row plus a linear address register lin = row*COLS+col, updated incrementally. No multiplier.
- in_ready=1 only in IDLE. A byte accepted in cycle N is decoded in IDLE at cycle N. Actions start at cycle N+1.
- Printable 0x20..0x7E: one write cycle (WRITE: cs=1, wr=1, addr=lin, data=char). Then col++. If col was 79: col=0 and row++.
- 0x0D CR: col=0. No memory access.
- 0x0A LF: col=0, row++.
- 0x08 BS: if col>0: col--, then one write of BLANK at the new lin. If col=0: no-op. No reverse wrap across rows.
- 0x0C FF: go to CLEAR_ALL, then cursor 0,0.
- All other codes are accepted and discarded. in_ready returns next cycle.
- Row overflow: any row++ from row 29 sets row=29 and enters SCROLL.
- SCROLL copies dst=0..2319 from src=dst+80:
  - SCROLL_RD: cs=1, wr=0, addr=src.
  - SCROLL_WR: cs=1, wr=1, addr=dst, data=buf_readdata.
  - Two cycles per byte, 4640 cycles total.
- After SCROLL, CLEAR_ROW writes BLANK to addresses 2320..2399 (80 cycles), then returns to IDLE.
- CLEAR_ALL writes BLANK to 0..2399, one per cycle (2400 cycles). Cursor is set to 0,0 on exit.
- The scroll/clear counter is 12 bits. Terminal values are 2319, 2399 and 79 (CLEAR_ROW local count). No wrap past 2399. Addresses >= 2400 are never driven.
- Outside active cycles, buf_chipselect=0 and buf_write=0.
- States: IDLE, WRITE, SCROLL_RD, SCROLL_WR, CLEAR_ROW, CLEAR_ALL.
- busy = (state != IDLE). cursor_* update on the cycle the action completes.
- Reset mid-operation aborts immediately. Partial buffer contents are acceptable. Post-reset behaviour is as above.
- A printable char at 29,79 writes first, then scrolls. Cursor ends at 29,0.

Decomposition:
- Package elc3_console_pkg: COLS/ROWS/BLANK constants, control-code constants (CR, LF, BS, FF), state enum, SCREEN_CELLS=2400, SCROLL_CELLS=2320.
- One sub-module: elc3_console_cursor (col/row/lin registers with inc, newline, cr, bs, home ops, and an overflow flag).
- The FSM and memory-port sequencing stay in the top.

Test Plan:
- Reset with CLEAR_ON_RESET=1 -> busy for 2400 cycles; every address 0..2399 = 0x20; then in_ready=1, cursor 0,0.
- Send "A","B" -> addr 0=0x41, addr 1=0x42; cursor 0,2; each accept followed by exactly one write cycle.
- Send 80 x "x" then "y" -> addr 79=0x78, addr 80=0x79; cursor 1,1.
- Fill rows so row1 col0=0x51 and row29 col5=0x5A; cursor at 29,3; send LF -> 4640+80 busy cycles; addr 0=0x51, addr 2245=0x5A, addr 2320..2399=0x20; cursor 29,0.
- At cursor 3,10 send BS -> addr 249=0x20, cursor 3,9. At col 0 send BS -> no write, cursor unchanged. Send 0x07 -> discarded, no bus activity.
- Assert reset_n=0 mid-SCROLL -> chipselect/write drop asynchronously; after release, CLEAR_ALL runs and cursor is 0,0.
